fwd_hazard_unit: RTL

- Parametrised successor to the pipeline forwarding unit.
- Tracks in-flight register writers in an internal shadow pipeline covering EX through WB.
- Produces a forward select for each of NUM_SRC source operands of the instruction in EX.
- Detects use-before-ready hazards for the instruction in ID, for any per-instruction result latency: ALU, load, multi-cycle. Drives the ID stall, inserts bubbles and counts stall cycles.

---
 rtl/fwd_hazard_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: shadow pipeline of in-flight writers (EX..WB),
// per-operand EX forward selects, and ID use-before-ready stall detection.
`timescale 1ns/1ps

module fwd_hazard_unit #(
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned DEPTH   = 3,
   parameter int unsigned MAX_LAT = 2,
   parameter int unsigned SEL_W   = $clog2(DEPTH),
   parameter int unsigned LAT_W   = $clog2(MAX_LAT + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       hold_i,
   input  logic                       flush_i,
   input  logic                       id_valid_i,
   input  logic [NUM_SRC*5-1:0]       id_rs_i,
   input  logic [NUM_SRC-1:0]         id_rs_used_i,
   input  logic [4:0]                 id_rd_i,
   input  logic                       id_load_regfile_i,
   input  logic [LAT_W-1:0]           id_lat_i,
   output logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel_o,
   output logic                       ex_valid_o,
   output logic                       stall_o,
   output logic [31:0]                stall_count_o
);

   localparam int unsigned REG_W = 5;

   // A result must be forwardable before the shadow pipe runs out of stages.
   if (MAX_LAT < 1 || MAX_LAT > DEPTH - 1) begin : g_bad_lat
      $error("fwd_hazard_unit: MAX_LAT must satisfy 1 <= MAX_LAT <= DEPTH-1");
   end

   // Shadow pipeline state; index 0 is EX, DEPTH-1 is WB.
   logic [DEPTH-1:0]                  r_valid;
   logic [DEPTH-1:0]                  r_wr;
   logic [DEPTH-1:0][REG_W-1:0]       r_rd;
   logic [DEPTH-1:0][LAT_W-1:0]       r_lat;
   logic [NUM_SRC-1:0][REG_W-1:0]     r_rs;
   logic [NUM_SRC-1:0]                r_used;
   logic [31:0]                       r_stall_cnt;

   logic [NUM_SRC-1:0]                w_fnd;
   logic [NUM_SRC-1:0]                w_haz;
   logic                              w_stall;
   logic                              w_bubble;
   logic [NUM_SRC-1:0]                w_efnd;
   logic [NUM_SRC-1:0]                w_unreach;
   logic [NUM_SRC-1:0][SEL_W-1:0]     w_sel;
   logic [LAT_W-1:0]                  w_in_lat;

   // ID hazard: youngest matching writer decides whether its value is ready in time.
   always_comb begin
      w_fnd = '0;
      w_haz = '0;
      for (int unsigned j = 0; j < NUM_SRC; j++) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!w_fnd[j] && r_valid[k] && r_wr[k] &&
                (r_rd[k] == id_rs_i[REG_W*j +: REG_W]) &&
                (id_rs_i[REG_W*j +: REG_W] != '0)) begin
               w_fnd[j] = 1'b1;
               w_haz[j] = id_rs_used_i[j] && ((k + 1) < 32'(r_lat[k]));
            end
         end
      end
   end

   assign w_stall  = id_valid_i & (|w_haz) & ~flush_i;
   assign w_bubble = w_stall | flush_i | ~id_valid_i;
   assign w_in_lat = (id_lat_i == '0) ? LAT_W'(1) : id_lat_i;

   // EX forward select: youngest matching writer in MEM..WB whose result already exists.
   always_comb begin
      w_sel     = '0;
      w_efnd    = '0;
      w_unreach = '0;
      for (int unsigned j = 0; j < NUM_SRC; j++) begin
         if (r_valid[0] && r_used[j] && (r_rs[j] != '0)) begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
               if (!w_efnd[j] && r_valid[k] && r_wr[k] && (r_rd[k] == r_rs[j])) begin
                  w_efnd[j] = 1'b1;
                  if (k >= 32'(r_lat[k])) w_sel[j] = SEL_W'(k);
                  else                    w_unreach[j] = 1'b1;
               end
            end
         end
      end
   end

   // The ID stall guarantees no EX consumer ever meets an unfinished producer.
   a_no_unready_fwd: assert property (@(posedge clk) disable iff (!rst) (w_unreach == '0));

   // Shadow pipeline advance, bubble insertion and saturating stall counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_valid     <= '0;
         r_wr        <= '0;
         r_rd        <= '0;
         r_lat       <= '0;
         r_rs        <= '0;
         r_used      <= '0;
         r_stall_cnt <= '0;
      end else if (!hold_i) begin
         if (w_bubble) begin
            r_valid <= {r_valid[DEPTH-2:0], 1'b0};
            r_wr    <= {r_wr[DEPTH-2:0], 1'b0};
            r_rd    <= {r_rd[DEPTH-2:0], REG_W'(0)};
            r_lat   <= {r_lat[DEPTH-2:0], LAT_W'(0)};
            r_rs    <= '0;
            r_used  <= '0;
         end else begin
            r_valid <= {r_valid[DEPTH-2:0], 1'b1};
            r_wr    <= {r_wr[DEPTH-2:0], (id_load_regfile_i && (id_rd_i != '0))};
            r_rd    <= {r_rd[DEPTH-2:0], id_rd_i};
            r_lat   <= {r_lat[DEPTH-2:0], w_in_lat};
            r_rs    <= id_rs_i;
            r_used  <= id_rs_used_i;
         end
         if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
      end
   end

   assign ex_fwd_sel_o  = w_sel;
   assign ex_valid_o    = r_valid[0];
   assign stall_o       = w_stall;
   assign stall_count_o = r_stall_cnt;

endmodule
